// File: rtl/vm2_board_pkg.sv
// Shared types and default constants for the VM2 board-level local-bus controller.
package vm2_board_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROM_WAIT,
    EXT_WAIT,
    DONE
  } ack_state_e;

  localparam logic [15:0] STARTUP_DEFAULT = 16'o140001;
  localparam logic [3:0]  ROM_WIN_DEFAULT = 4'b1110;
  localparam logic [3:0]  RAM_WIN_DEFAULT = 4'b1111;

endpackage

// File: rtl/vm2_btn_debounce.sv
// Timer-enable button logic: synchronisers, 50 Hz edge detect, debounce run
// counter and press latch driving the timer_status toggle and timer events.
module vm2_btn_debounce #(
  parameter int unsigned DEB_LEN = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic t50_i,
  input  logic btn_i,
  output logic status_o,
  output logic evnt_o
);

  localparam int unsigned   CW      = 4;
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_LEN);

  logic [1:0]    t50_sync_q, btn_sync_q;
  logic          t50_prev_q, btn_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          latch_q, latch_d;
  logic          status_q, status_d;
  logic          t50_edge, btn_s;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v >= DEB_MAX) ? DEB_MAX : v + CW'(1);
  endfunction

  assign t50_edge = t50_sync_q[1] & ~t50_prev_q;
  assign btn_s    = btn_sync_q[1];
  assign status_o = status_q;
  assign evnt_o   = t50_edge & status_q;

  always_comb begin
    cnt_d    = cnt_q;
    latch_d  = latch_q;
    status_d = status_q;
    if (t50_edge) begin
      cnt_d = (btn_s == btn_prev_q) ? sat_inc(cnt_q) : CW'(1);
      // The latch makes a held press toggle once; only a stable release re-arms it
      if (cnt_d == DEB_MAX) begin
        if (btn_s && !latch_q) begin
          status_d = ~status_q;
          latch_d  = 1'b1;
        end else if (!btn_s) begin
          latch_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      t50_sync_q <= '0;
      btn_sync_q <= '0;
      t50_prev_q <= 1'b0;
      btn_prev_q <= 1'b0;
      cnt_q      <= '0;
      latch_q    <= 1'b0;
      status_q   <= 1'b1;
    end else begin
      t50_sync_q <= {t50_sync_q[0], t50_i};
      btn_sync_q <= {btn_sync_q[0], btn_i};
      t50_prev_q <= t50_sync_q[1];
      if (t50_edge) btn_prev_q <= btn_s;
      cnt_q      <= cnt_d;
      latch_q    <= latch_d;
      status_q   <= status_d;
    end
  end

endmodule

// File: rtl/vm2_board_ctl.sv
// VM2 board local-bus controller: address decode, ack/timeout FSM, CPU
// slow-down clock enable, startup vector mux and 50 Hz timer enable.
module vm2_board_ctl
  import vm2_board_pkg::*;
#(
  parameter logic [15:0] STARTUP  = STARTUP_DEFAULT,
  parameter logic [3:0]  ROM_WIN  = ROM_WIN_DEFAULT,
  parameter logic [3:0]  RAM_WIN  = RAM_WIN_DEFAULT,
  parameter int unsigned ROM_WS   = 1,
  parameter int unsigned TMO_CYC  = 255,
  parameter int unsigned SLOW_DIV = 21,
  parameter int unsigned DEB_LEN  = 2
) (
  input  logic        clk_p,
  input  logic        rst_n,
  input  logic        cpuslow,
  output logic        cpu_clk_ena,
  input  logic [16:0] full_adr,
  input  logic        local_cyc,
  input  logic        local_stb,
  output logic        cpu_ack,
  output logic        bus_err,
  input  logic [15:0] rom_dat,
  output logic        rom_stb,
  input  logic [15:0] cpu_dat_i,
  output logic [15:0] local_dat_o,
  output logic        sysram_stb,
  input  logic        global_ack,
  output logic        cpu_cyc_o,
  input  logic        una,
  input  logic [15:0] ivec,
  input  logic        cpu_istb,
  output logic [15:0] vector,
  output logic        istb,
  input  logic        timer_50,
  input  logic        timer_button,
  output logic        timer_status,
  output logic        evnt
);

  localparam int unsigned   TW        = $clog2(TMO_CYC);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TMO_CYC - 1);
  localparam logic [4:0]    SLOW_LAST = 5'(SLOW_DIV - 1);

  ack_state_e    state_q, state_d;
  logic [2:0]    ws_q, ws_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [4:0]    div_q, div_d;
  logic          slow_q;
  logic          unused_adr;

  assign unused_adr  = ^full_adr[12:0];

  assign rom_stb     = local_cyc & local_stb & (full_adr[16:13] == ROM_WIN);
  assign sysram_stb  = local_cyc & local_stb & (full_adr[16:13] == RAM_WIN);
  assign local_dat_o = rom_stb ? rom_dat : cpu_dat_i;
  assign cpu_cyc_o   = local_cyc & ~full_adr[16];

  assign vector      = una ? STARTUP : ivec;
  assign istb        = cpu_istb & ~una;

  always_comb begin
    state_d = state_q;
    ws_d    = ws_q;
    tmo_d   = tmo_q;
    cpu_ack = 1'b0;
    bus_err = 1'b0;
    if (!local_cyc) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (local_stb) begin
            if (rom_stb) begin
              state_d = ROM_WAIT;
              ws_d    = 3'(ROM_WS);
            end else begin
              state_d = EXT_WAIT;
              tmo_d   = '0;
            end
          end
        end
        ROM_WAIT: begin
          if (ws_q == 3'd0) begin
            cpu_ack = 1'b1;
            state_d = DONE;
          end else begin
            ws_d = ws_q - 3'd1;
          end
        end
        EXT_WAIT: begin
          // A real ack wins over a timeout landing on the same cycle
          if (global_ack) begin
            cpu_ack = 1'b1;
            state_d = DONE;
          end else if (tmo_q == TMO_LAST) begin
            cpu_ack = 1'b1;
            bus_err = 1'b1;
            state_d = DONE;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        DONE: begin
          if (!local_stb) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Divider restarts from 0 whenever cpuslow changes and idles at 0 in fast mode
  always_comb begin
    div_d = '0;
    if (cpuslow && (cpuslow == slow_q) && (div_q != SLOW_LAST)) div_d = div_q + 5'd1;
  end

  assign cpu_clk_ena = ~cpuslow | (div_q == 5'd0);

  always_ff @(posedge clk_p) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ws_q    <= '0;
      tmo_q   <= '0;
      div_q   <= '0;
      slow_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ws_q    <= ws_d;
      tmo_q   <= tmo_d;
      div_q   <= div_d;
      slow_q  <= cpuslow;
    end
  end

  vm2_btn_debounce #(
    .DEB_LEN (DEB_LEN)
  ) u_btn (
    .clk_i    (clk_p),
    .rst_ni   (rst_n),
    .t50_i    (timer_50),
    .btn_i    (timer_button),
    .status_o (timer_status),
    .evnt_o   (evnt)
  );

endmodule

// File: tb/tb_vm2_board_ctl.sv
// Self-checking bench for vm2_board_ctl: randomized bus transactions, clock
// enable, vector mux and button debounce against a behavioural model.
module tb_vm2_board_ctl;

  localparam logic [15:0] STARTUP = 16'o140001;
  localparam logic [3:0]  ROM_WIN = 4'b1110;
  localparam logic [3:0]  RAM_WIN = 4'b1111;
  localparam int ROM_WS = 1;
  localparam int TMO    = 8;
  localparam int SLOW   = 21;
  localparam int DEB    = 2;

  logic        clk_p = 1'b0;
  logic        rst_n, cpuslow, cpu_clk_ena;
  logic [16:0] full_adr;
  logic        local_cyc, local_stb, cpu_ack, bus_err;
  logic [15:0] rom_dat, cpu_dat_i, local_dat_o;
  logic        rom_stb, sysram_stb, global_ack, cpu_cyc_o;
  logic        una, cpu_istb, istb;
  logic [15:0] ivec, vector;
  logic        timer_50, timer_button, timer_status, evnt;

  int checks = 0;
  int errors = 0;

  // Timer model: sample history, press latch, expected status
  logic hist[$];
  bit   pressed;
  logic m_status;

  vm2_board_ctl #(
    .STARTUP (STARTUP), .ROM_WIN (ROM_WIN), .RAM_WIN (RAM_WIN), .ROM_WS (ROM_WS),
    .TMO_CYC (TMO), .SLOW_DIV (SLOW), .DEB_LEN (DEB)
  ) dut (
    .clk_p (clk_p), .rst_n (rst_n), .cpuslow (cpuslow), .cpu_clk_ena (cpu_clk_ena),
    .full_adr (full_adr), .local_cyc (local_cyc), .local_stb (local_stb),
    .cpu_ack (cpu_ack), .bus_err (bus_err), .rom_dat (rom_dat), .rom_stb (rom_stb),
    .cpu_dat_i (cpu_dat_i), .local_dat_o (local_dat_o), .sysram_stb (sysram_stb),
    .global_ack (global_ack), .cpu_cyc_o (cpu_cyc_o), .una (una), .ivec (ivec),
    .cpu_istb (cpu_istb), .vector (vector), .istb (istb), .timer_50 (timer_50),
    .timer_button (timer_button), .timer_status (timer_status), .evnt (evnt)
  );

  always #5 clk_p = ~clk_p;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic model_reset;
    hist.delete();
    pressed  = 1'b0;
    m_status = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cpuslow = 1'b1; full_adr = '0; local_cyc = 1'b0; local_stb = 1'b0;
    rom_dat = '0; cpu_dat_i = '0; global_ack = 1'b0; una = 1'b0; ivec = '0;
    cpu_istb = 1'b0; timer_50 = 1'b0; timer_button = 1'b0;
    repeat (3) @(negedge clk_p);
    #1;
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_cpu_ack: got %b want 0", cpu_ack); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
    checks++; if (timer_status !== 1'b1) begin errors++; $display("FAIL reset_timer_status: got %b want 1", timer_status); end
    checks++; if (cpu_clk_ena !== 1'b1) begin errors++; $display("FAIL reset_cpu_clk_ena: got %b want 1", cpu_clk_ena); end
    checks++; if (evnt !== 1'b0) begin errors++; $display("FAIL reset_evnt: got %b want 0", evnt); end
    checks++; if ({rom_stb, sysram_stb, cpu_cyc_o, istb} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes: got %b want 0000", {rom_stb, sysram_stb, cpu_cyc_o, istb});
    end
    @(negedge clk_p);
    rst_n = 1'b1; cpuslow = 1'b0;
    model_reset();
  endtask

  // One local transaction; gd = cycle after stb on which global_ack pulses
  task automatic run_tx(input logic [16:0] adr, input logic [15:0] rd, input int gd, input string tag);
    logic [15:0] gdat;
    bit is_rom, is_ram, tmo;
    int ack_cyc;
    gdat   = 16'($urandom);
    is_rom = (adr[16:13] == ROM_WIN);
    is_ram = (adr[16:13] == RAM_WIN);
    tmo    = 1'b0;
    if (is_rom) ack_cyc = ROM_WS + 1;
    else if (gd >= 1 && gd <= TMO) ack_cyc = gd;
    else begin ack_cyc = TMO; tmo = 1'b1; end
    @(negedge clk_p);
    full_adr = adr; local_cyc = 1'b1; local_stb = 1'b1;
    rom_dat = rd; cpu_dat_i = gdat; global_ack = 1'b0;
    #1;
    checks++; if (rom_stb !== is_rom) begin errors++; $display("FAIL %s rom_stb: got %b want %b", tag, rom_stb, is_rom); end
    checks++; if (sysram_stb !== is_ram) begin errors++; $display("FAIL %s sysram_stb: got %b want %b", tag, sysram_stb, is_ram); end
    checks++; if (cpu_cyc_o !== ~adr[16]) begin errors++; $display("FAIL %s cpu_cyc_o: got %b want %b", tag, cpu_cyc_o, ~adr[16]); end
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL %s ack_at_stb: got %b want 0", tag, cpu_ack); end
    for (int c = 1; c <= ack_cyc + 2; c++) begin
      @(negedge clk_p);
      global_ack = (c == gd);
      #1;
      checks++;
      if (cpu_ack !== (c == ack_cyc)) begin
        errors++; $display("FAIL %s cpu_ack cycle %0d: got %b want %b", tag, c, cpu_ack, (c == ack_cyc));
      end
      checks++;
      if (bus_err !== (c == ack_cyc && tmo)) begin
        errors++; $display("FAIL %s bus_err cycle %0d: got %b want %b", tag, c, bus_err, (c == ack_cyc && tmo));
      end
      if (c == ack_cyc) begin
        checks++;
        if (local_dat_o !== (is_rom ? rd : gdat)) begin
          errors++; $display("FAIL %s local_dat_o: got %o want %o", tag, local_dat_o, (is_rom ? rd : gdat));
        end
      end
    end
    @(negedge clk_p);
    local_stb = 1'b0; local_cyc = 1'b0; global_ack = 1'b0;
  endtask

  task automatic test_decode_rom;
    run_tx(17'o340000, 16'o012737, 0, "rom_read");
  endtask

  task automatic test_timeout;
    run_tx(17'o001000, 16'($urandom), 0, "global_timeout");
    run_tx(17'o001000, 16'($urandom), TMO, "ack_on_timeout");
  endtask

  task automatic test_global_ack;
    run_tx(17'o360000, 16'($urandom), 3, "sysram_ack3");
    run_tx(17'o160000, 16'($urandom), 3, "global_ack3");
  endtask

  task automatic test_back_to_back;
    logic [16:0] adr;
    int kind;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      adr  = 17'($urandom);
      if (kind == 0) adr[16:13] = ROM_WIN;
      else if (kind == 1) adr[16:13] = RAM_WIN;
      else adr[16:13] = 4'($urandom_range(0, 13));
      run_tx(adr, 16'($urandom), $urandom_range(1, TMO + 3), "random_tx");
    end
  endtask

  task automatic test_abort;
    @(negedge clk_p);
    full_adr = 17'o001000; local_cyc = 1'b1; local_stb = 1'b1; global_ack = 1'b0;
    repeat (3) @(negedge clk_p);
    local_cyc = 1'b0; global_ack = 1'b1;
    #1;
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL abort_ack: got %b want 0", cpu_ack); end
    // A fresh timeout must take the full TMO cycles from the restart
    run_tx(17'o001000, 16'($urandom), TMO + 3, "after_abort");
  endtask

  task automatic test_una;
    logic [15:0] exp_vec;
    logic exp_istb;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_p);
      if (i == 0) begin una = 1'b1; cpu_istb = 1'b1; ivec = 16'o000060; end
      else if (i == 1) begin una = 1'b0; cpu_istb = 1'b1; ivec = 16'o000060; end
      else begin una = 1'($urandom); cpu_istb = 1'($urandom); ivec = 16'($urandom); end
      #1;
      exp_vec  = una ? STARTUP : ivec;
      exp_istb = cpu_istb & ~una;
      checks++; if (vector !== exp_vec) begin errors++; $display("FAIL una_vector %0d: got %o want %o", i, vector, exp_vec); end
      checks++; if (istb !== exp_istb) begin errors++; $display("FAIL una_istb %0d: got %b want %b", i, istb, exp_istb); end
    end
    @(negedge clk_p);
    una = 1'b0; cpu_istb = 1'b0;
  endtask

  task automatic test_slow;
    int run;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk_p);
      cpuslow = 1'b1;
      run = $urandom_range(2 * SLOW, 4 * SLOW);
      for (int c = 1; c <= run; c++) begin
        @(negedge clk_p); #1;
        checks++;
        if (cpu_clk_ena !== ((c - 1) % SLOW == 0)) begin
          errors++; $display("FAIL slow_ena cycle %0d: got %b want %b", c, cpu_clk_ena, ((c - 1) % SLOW == 0));
        end
      end
      @(negedge clk_p);
      cpuslow = 1'b0;
      for (int c = 0; c < 5; c++) begin
        #1;
        checks++; if (cpu_clk_ena !== 1'b1) begin errors++; $display("FAIL fast_ena cycle %0d: got %b want 1", c, cpu_clk_ena); end
        @(negedge clk_p);
      end
    end
  endtask

  task automatic t50_pulse(input logic b);
    int ev, exp_ev, run;
    @(negedge clk_p);
    timer_button = b;
    repeat (4) @(negedge clk_p);
    timer_50 = 1'b1;
    ev = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_p); #1;
      if (evnt === 1'b1) ev++;
    end
    timer_50 = 1'b0;
    repeat (4) @(negedge clk_p);
    exp_ev = m_status ? 1 : 0;
    hist.push_back(b);
    run = 0;
    for (int k = hist.size() - 1; k >= 0 && hist[k] == b; k--) run++;
    if (run >= DEB) begin
      if (b && !pressed) begin m_status = ~m_status; pressed = 1'b1; end
      else if (!b) pressed = 1'b0;
    end
    checks++; if (ev != exp_ev) begin errors++; $display("FAIL evnt_count btn=%b: got %0d want %0d", b, ev, exp_ev); end
    checks++; if (timer_status !== m_status) begin errors++; $display("FAIL timer_status btn=%b: got %b want %b", b, timer_status, m_status); end
  endtask

  task automatic test_timer;
    logic seq [12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    foreach (seq[i]) t50_pulse(seq[i]);
    for (int i = 0; i < 20; i++) t50_pulse(1'($urandom));
  endtask

  task automatic test_reset_midop;
    for (int i = 0; i < 3 && m_status; i++) begin
      t50_pulse(1'b0); t50_pulse(1'b0); t50_pulse(1'b1); t50_pulse(1'b1);
    end
    @(negedge clk_p);
    full_adr = 17'o001000; local_cyc = 1'b1; local_stb = 1'b1; global_ack = 1'b0;
    repeat (3) @(negedge clk_p);
    rst_n = 1'b0;
    for (int c = 0; c < TMO + 2; c++) begin
      @(negedge clk_p);
      global_ack = 1'($urandom);
      #1;
      checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL midreset_ack %0d: got %b want 0", c, cpu_ack); end
      checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL midreset_err %0d: got %b want 0", c, bus_err); end
    end
    checks++; if (timer_status !== 1'b1) begin errors++; $display("FAIL midreset_timer_status: got %b want 1", timer_status); end
    @(negedge clk_p);
    local_cyc = 1'b0; local_stb = 1'b0; global_ack = 1'b0;
    @(negedge clk_p);
    rst_n = 1'b1;
    model_reset();
    run_tx(17'o340000, 16'($urandom), 0, "after_reset_rom");
    t50_pulse(1'b1);
    t50_pulse(1'b1);
  endtask

  initial begin
    test_reset();
    test_una();
    test_decode_rom();
    test_timeout();
    test_global_ack();
    test_back_to_back();
    test_abort();
    test_slow();
    test_timer();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vm2_board_ctl.md
Name: vm2_board_ctl

Overview:
- Parametrised local-bus controller for VM2-class processor boards; sits between the vm2_wb core and the board-level Wishbone bus.
- Decodes the 17-bit local address (bit 16 = SEL) into a shadow ROM window, a shadow system-RAM window and the global bus.
- Inserts ROM wait states and times out unanswered global cycles with a bus-error acknowledge.
- Generates the programmable CPU slow-down enable and the startup vector mux. Owns the debounced 50 Hz timer-enable toggle, sampled synchronously on the core clock.

Parameters:
- STARTUP, 16'o140001, value returned on unaddressed (UNA) read.
- ROM_WIN, 4'b1110, full_adr[16:13] match for the shadow ROM.
- RAM_WIN, 4'b1111, full_adr[16:13] match for shadow system RAM.
- ROM_WS, 1, ROM wait states before ack (0..7).
- TMO_CYC, 255, global-bus timeout in clk_p cycles (>=2).
- SLOW_DIV, 21, slow-mode enable period (2..31).
- DEB_LEN, 2, consecutive equal 50 Hz samples required to accept a button level (1..8).

Ports:
- clk_p  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- cpuslow  in  1  1 = slow mode
- cpu_clk_ena  out  1  clock enable to core
- full_adr  in  17  local address incl. SEL
- local_cyc  in  1  core cycle strobe
- local_stb  in  1  core data strobe
- cpu_ack  out  1  ack to core
- bus_err  out  1  pulses with a timeout ack
- rom_dat  in  16  ROM data (registered, valid ROM_WS cycles after stb)
- rom_stb  out  1  ROM select
- cpu_dat_i  in  16  global bus read data
- local_dat_o  out  16  muxed read data to core
- sysram_stb  out  1  shadow RAM select
- global_ack  in  1  ack from global bus and shadow RAM
- cpu_cyc_o  out  1  global cycle (local_cyc & ~full_adr[16])
- una  in  1  core UNA strobe
- ivec  in  16  interrupt vector
- cpu_istb  in  1  core vector strobe
- vector  out  16  vector/startup mux to core
- istb  out  1  vector strobe to interrupt controller (0 during UNA)
- timer_50  in  1  50 Hz level, asynchronous
- timer_button  in  1  raw button, asynchronous
- timer_status  out  1  timer enable state
- evnt  out  1  one-cycle timer event to core

Behaviour:
- Reset values: all outputs 0 except timer_status=1 and cpu_clk_ena=1. FSM resets to IDLE, divider to 0, debounce counter to 0.
- Decode (combinational): rom_stb = local_cyc & local_stb & (full_adr[16:13]==ROM_WIN). sysram_stb = the same with RAM_WIN. local_dat_o = rom_stb ? rom_dat : cpu_dat_i.
- Ack FSM:
  - IDLE -> ROM_WAIT on rom_stb; ws counter loaded with ROM_WS.
  - IDLE -> EXT_WAIT on any other local_cyc&local_stb; timeout counter cleared.
  - ROM_WAIT: decrement each cycle; at 0 assert cpu_ack for 1 cycle -> DONE. With ROM_WS=0, ack comes the cycle after stb.
  - EXT_WAIT: global_ack -> cpu_ack same cycle (combinational pass-through) -> DONE.
  - EXT_WAIT timeout: when the counter reaches TMO_CYC-1 with no global_ack, assert cpu_ack and bus_err together for 1 cycle -> DONE.
  - DONE: wait for local_stb low -> IDLE. cpu_ack=0 in DONE.
  - local_cyc dropping in any state aborts to IDLE with no ack.
  - global_ack on the same cycle as timeout: normal ack, bus_err=0.
- UNA: vector = una ? STARTUP : ivec. istb = cpu_istb & ~una.
- Clock enable:
  - cpuslow=0: cpu_clk_ena=1 constantly.
  - cpuslow=1: the divider counts 0..SLOW_DIV-1 and wraps; cpu_clk_ena=1 only at count 0.
  - Toggling cpuslow resets the divider to 0 on the next cycle.
- Timer:
  - timer_50 and timer_button each pass through a 2-flop synchroniser.
  - A rising edge of synced timer_50 gives t50_edge (1 cycle).
  - evnt = t50_edge & timer_status.
  - On each t50_edge, the button is sampled. If the sample equals the previous sample, the debounce counter increments (saturating at DEB_LEN); otherwise it clears to 1.
  - When the count reaches DEB_LEN at level 1 and the latch is 0: toggle timer_status and set the latch.
  - When the count reaches DEB_LEN at level 0: clear the latch.
  - Exactly one toggle per press.
- Reset mid-operation: FSM returns to IDLE with no spurious ack; timer_status returns to 1.

Decomposition:
- Package vm2_board_pkg holds the FSM state enum (IDLE, ROM_WAIT, EXT_WAIT, DONE), default window codes, and STARTUP_DEFAULT.
- Sub-module vm2_btn_debounce (synchroniser, edge detect, DEB_LEN counter, toggle latch) is instantiated once.

Test Plan:
- ROM read at full_adr=17'o340000, ROM_WS=1, rom_dat=16'o012737 -> cpu_ack exactly 2 cycles after stb, local_dat_o=16'o012737, cpu_cyc_o=0.
- Global read at 17'o001000, global_ack held 0, TMO_CYC=8 -> cpu_ack and bus_err high together on the 8th cycle, then FSM in DONE until stb drops.
- Global access with global_ack on cycle 3 -> cpu_ack same cycle, bus_err=0. sysram_stb=1 for 17'o360000, 0 for 17'o160000.
- una=1, ivec=16'o000060 -> vector=16'o140001, istb=0 while cpu_istb=1. With una=0 -> vector=16'o000060, istb follows cpu_istb.
- cpuslow=1, SLOW_DIV=21 -> cpu_clk_ena high 1 cycle in every 21. Drop cpuslow -> constant 1 next cycle.
- Button held high for 3 timer_50 edges, DEB_LEN=2 -> timer_status 1->0 once and evnt suppressed afterwards. Release, then press again -> timer_status returns to 1. A bounce 1-0-1 across single edges -> no toggle.
